// File: rtl/fft_loader.sv
// fft_loader: writes a 1024-point stream of q1.15 samples into two BSRAM banks in bit-reversed order.
// It then runs the start / finish / clear handshake with the FFT core and reports frame_done.
module fft_loader #(
  parameter int SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        flush,
  output logic        ce0,
  output logic        wre0,
  output logic [10:0] ad0,
  output logic [31:0] din0,
  output logic        ce1,
  output logic        wre1,
  output logic [10:0] ad1,
  output logic [31:0] din1,
  output logic        fft_start,
  input  logic        fft_finish,
  output logic        fft_clear,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_KICK = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         n_q, n_d;
  logic               kclr_q, kclr_d;
  logic               start_q, start_d;
  logic               clear_q, clear_d;
  logic               done_q, done_d;
  logic               ce0_q, ce0_d;
  logic               ce1_q, ce1_d;
  logic [10:0]        ad0_q, ad0_d;
  logic [10:0]        ad1_q, ad1_d;
  logic [31:0]        din0_q, din0_d;
  logic [31:0]        din1_q, din1_d;
  logic               accept;
  logic [9:0]         rev;
  logic signed [15:0] re_sh;
  logic signed [15:0] im_sh;

  assign s_ready = (state_q == S_LOAD) && !flush;
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != S_LOAD);

  assign re_sh = $signed(s_data[31:16]) >>> SHIFT;
  assign im_sh = $signed(s_data[15:0]) >>> SHIFT;

  always_comb begin
    rev = '0;
    for (int i = 0; i < 10; i++) begin
      rev[i] = n_q[9-i];
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    kclr_d  = 1'b0;
    start_d = 1'b0;
    clear_d = 1'b0;
    done_d  = 1'b0;
    ce0_d   = 1'b0;
    ce1_d   = 1'b0;
    ad0_d   = ad0_q;
    ad1_d   = ad1_q;
    din0_d  = din0_q;
    din1_d  = din1_q;

    // The top bit of the reversed index (n[0]) picks the bank.
    if (accept) begin
      if (rev[9]) begin
        ce1_d  = 1'b1;
        ad1_d  = {2'b00, rev[8:0]};
        din1_d = {re_sh, im_sh};
      end else begin
        ce0_d  = 1'b1;
        ad0_d  = {2'b00, rev[8:0]};
        din0_d = {re_sh, im_sh};
      end
    end

    case (state_q)
      S_LOAD: begin
        if (flush) begin
          n_d = '0;
        end else if (accept) begin
          n_d = n_q + 10'd1;
          if (n_q == 10'd1023) begin
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        // A finish left over from an earlier run is acknowledged before starting.
        if (fft_finish && !kclr_q) begin
          clear_d = 1'b1;
          kclr_d  = 1'b1;
        end else begin
          start_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fft_finish) begin
          clear_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_LOAD;
        n_d     = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      n_q     <= '0;
      kclr_q  <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      ce0_q   <= 1'b0;
      ce1_q   <= 1'b0;
      ad0_q   <= '0;
      ad1_q   <= '0;
      din0_q  <= '0;
      din1_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      kclr_q  <= kclr_d;
      start_q <= start_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      ce0_q   <= ce0_d;
      ce1_q   <= ce1_d;
      ad0_q   <= ad0_d;
      ad1_q   <= ad1_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
    end
  end

  assign ce0        = ce0_q;
  assign wre0       = ce0_q;
  assign ad0        = ad0_q;
  assign din0       = din0_q;
  assign ce1        = ce1_q;
  assign wre1       = ce1_q;
  assign ad1        = ad1_q;
  assign din1       = din1_q;
  assign fft_start  = start_q;
  assign fft_clear  = clear_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fft_loader.sv
// Bench for fft_loader: a frame-level model tracks expected writes and handshake timing every cycle.
// A second instance with SHIFT=2 shares all inputs to cover the scaling path.
module tb_fft_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready, h_s_ready;
  logic [31:0] s_data;
  logic        flush;
  logic        ce0, wre0, ce1, wre1, h_ce0, h_wre0, h_ce1, h_wre1;
  logic [10:0] ad0, ad1, h_ad0, h_ad1;
  logic [31:0] din0, din1, h_din0, h_din1;
  logic        fft_start, fft_clear, frame_done, busy;
  logic        h_fft_start, h_fft_clear, h_frame_done, h_busy;
  logic        fft_finish;

  fft_loader #(.SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .ce0(ce0), .wre0(wre0), .ad0(ad0), .din0(din0),
    .ce1(ce1), .wre1(wre1), .ad1(ad1), .din1(din1), .fft_start(fft_start),
    .fft_finish(fft_finish), .fft_clear(fft_clear), .frame_done(frame_done), .busy(busy)
  );

  fft_loader #(.SHIFT(2)) dut_sh (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(h_s_ready), .s_data(s_data),
    .flush(flush), .ce0(h_ce0), .wre0(h_wre0), .ad0(h_ad0), .din0(h_din0),
    .ce1(h_ce1), .wre1(h_wre1), .ad1(h_ad1), .din1(h_din1), .fft_start(h_fft_start),
    .fft_finish(fft_finish), .fft_clear(h_fft_clear), .frame_done(h_frame_done), .busy(h_busy)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam int NEVER = 32'h7fff_ffff;

  // Model state (written by the compare process only)
  int          cyc = 0;
  int          cnt, load_at, start_at, kclr_at, ack_at, kick_at;
  bit          waiting;
  bit          pend_vld, pend_bank;
  int          pend_addr;
  logic [31:0] pend_din, pend_hdin;
  logic [31:0] frame_in [1024];
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  int          n_start = 0, n_done = 0;
  int          obs_start_cyc, obs_done_cyc, obs_kclr_cyc, last_acc_cyc;
  int          seen_id = 0;
  bit          first_bank;
  int          first_ad;
  logic [31:0] first_din, first_hdin;
  bit          exp_load;
  int          rr, bad;
  logic [31:0] got;
  int          stale_seen = 0;
  int          fcnt = 0;

  // Driver-owned controls
  int arm_id = 0;
  int stale_cnt = 0;
  int fin_delay = 500;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int brev10(input int v);
    int r = 0;
    int m = v;
    for (int i = 0; i < 10; i++) begin
      r = r * 2 + m % 2;
      m = m / 2;
    end
    return r;
  endfunction

  // Floor division by 2**s on the signed value
  function automatic logic [15:0] sra16(input logic [15:0] v, input int s);
    int x, d, q;
    x = int'($signed(v));
    d = 1 << s;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q[15:0];
  endfunction

  // FFT core stand-in: finish rises fin_delay cycles after start, drops on clear.
  initial begin
    fft_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fft_finish = 1'b0;
        fcnt = 0;
      end else begin
        if (fft_clear) fft_finish = 1'b0;
        if (stale_cnt != stale_seen) begin
          fft_finish = 1'b1;
          stale_seen = stale_cnt;
        end
        if (fcnt > 0) begin
          fcnt--;
          if (fcnt == 0) fft_finish = 1'b1;
        end
        if (fft_start) fcnt = fin_delay;
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        cnt = 0; load_at = 0; start_at = -1; kclr_at = -1; ack_at = -1; kick_at = -1;
        waiting = 0; pend_vld = 0;
      end else begin
        cyc++;
        chk("ce0", ce0, pend_vld && !pend_bank);
        chk("wre0", wre0, pend_vld && !pend_bank);
        chk("ce1", ce1, pend_vld && pend_bank);
        chk("wre1", wre1, pend_vld && pend_bank);
        chk("sh_ce0", h_ce0, pend_vld && !pend_bank);
        chk("sh_ce1", h_ce1, pend_vld && pend_bank);
        if (pend_vld) begin
          if (!pend_bank) begin
            chk("ad0", ad0, 32'(pend_addr));
            chk("din0", din0, pend_din);
            chk("sh_din0", h_din0, pend_hdin);
          end else begin
            chk("ad1", ad1, 32'(pend_addr));
            chk("din1", din1, pend_din);
            chk("sh_din1", h_din1, pend_hdin);
          end
        end
        if (ce0 && wre0) mem0[ad0[8:0]] = din0;
        if (ce1 && wre1) mem1[ad1[8:0]] = din1;
        if (arm_id != seen_id && (ce0 || ce1)) begin
          seen_id    = arm_id;
          first_bank = ce1;
          first_ad   = ce1 ? int'(ad1) : int'(ad0);
          first_din  = ce1 ? din1 : din0;
          first_hdin = h_ce1 ? h_din1 : h_din0;
        end

        exp_load = (cyc >= load_at);
        chk("s_ready", s_ready, exp_load && !flush);
        chk("busy", busy, !exp_load);
        chk("fft_start", fft_start, cyc == start_at);
        chk("fft_clear", fft_clear, (cyc == kclr_at) || (cyc == ack_at));
        chk("frame_done", frame_done, cyc == ack_at);
        if (fft_start) begin n_start++; obs_start_cyc = cyc; end
        if (frame_done) begin n_done++; obs_done_cyc = cyc; end
        if (fft_clear && !frame_done) obs_kclr_cyc = cyc;

        pend_vld = 0;
        if (exp_load && flush) begin
          cnt = 0;
        end else if (exp_load && s_valid) begin
          rr        = brev10(cnt);
          pend_vld  = 1;
          pend_bank = (rr >= 512);
          pend_addr = rr % 512;
          pend_din  = {sra16(s_data[31:16], 0), sra16(s_data[15:0], 0)};
          pend_hdin = {sra16(s_data[31:16], 2), sra16(s_data[15:0], 2)};
          frame_in[cnt] = s_data;
          last_acc_cyc  = cyc;
          cnt++;
          if (cnt == 1024) begin
            cnt     = 0;
            load_at = NEVER;
            kick_at = cyc + 1;
          end
        end

        if (cyc == kick_at) begin
          bad = 0;
          for (int k = 0; k < 1024; k++) begin
            rr  = brev10(k);
            got = (rr < 512) ? mem0[rr] : mem1[rr-512];
            if (got !== frame_in[k]) bad++;
          end
          chk("frame_contents_bad", 32'(bad), 32'd0);
          if (fft_finish) begin
            kclr_at  = cyc + 1;
            start_at = cyc + 2;
          end else begin
            start_at = cyc + 1;
          end
          waiting = 1;
        end else if (waiting && cyc >= start_at && fft_finish) begin
          ack_at  = cyc + 1;
          load_at = cyc + 2;
          waiting = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gaps);
    for (int n = 0; n < 1024; n++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      if (mode == 0) send({16'(n), 16'h0000});
      else send($urandom);
    end
  endtask

  task automatic wait_done(input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      @(negedge clk);
      #1;
      if (frame_done) break;
    end
    s_valid = 1'b0;
    if (k == maxc) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no frame_done within %0d cycles", maxc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n0s, n0d;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce0", ce0, 0);  chk("rst_ce1", ce1, 0);
    chk("rst_start", fft_start, 0); chk("rst_clear", fft_clear, 0);
    chk("rst_done", frame_done, 0); chk("rst_busy", busy, 0);
    chk("rst_ad0", ad0, 0); chk("rst_din1", din1, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_reset", s_ready, 1);
    @(posedge clk); #1;

    // Scaling: SHIFT=2 of {8000,7FFF}
    arm_id++;
    send(32'h8000_7FFF);
    repeat (2) @(posedge clk);
    #1;
    chk("shift_captured", 32'(seen_id), 32'(arm_id));
    chk("shift_din", first_hdin, 32'hE000_1FFF);
    chk("noshift_din", first_din, 32'h8000_7FFF);
    chk("shift_bank", first_bank, 0);

    // Flush after 300 samples, then a full {n,0} frame with a 500-cycle core
    for (int i = 1; i < 300; i++) send($urandom);
    s_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b0;
    arm_id++;
    n0s = n_start;
    fin_delay = 500;
    send_frame(0, 0);
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    wait_done(1200);
    chk("flush_first_bank", first_bank, 0);
    chk("flush_first_ad", 32'(first_ad), 0);
    chk("flush_one_start", 32'(n_start - n0s), 1);
    chk("n1_at_bank1_0", mem1[0], 32'h0001_0000);
    chk("n2_at_bank0_256", mem0[256], 32'h0002_0000);
    chk("n1023_at_bank1_511", mem1[511], 32'h03FF_0000);
    chk("start_after_last_acc", 32'(obs_start_cyc - last_acc_cyc), 2);
    chk("done_after_start", 32'(obs_done_cyc - obs_start_cyc), 501);
    @(negedge clk); #1;
    chk("ready_after_ack", s_ready, 1);
    @(posedge clk); #1;

    // Stale finish present at kick time
    fin_delay = 10;
    stale_cnt++;
    send_frame(1, 0);
    wait_done(400);
    chk("stale_clear_then_start", 32'(obs_start_cyc - obs_kclr_cyc), 1);

    // Three frames with random gaps
    n0s = n_start; n0d = n_done;
    for (int f = 0; f < 3; f++) begin
      send_frame(1, 1);
      wait_done(400);
    end
    chk("gap_starts", 32'(n_start - n0s), 3);
    chk("gap_dones", 32'(n_done - n0d), 3);

    // Reset while waiting on the core
    fin_delay = 2000;
    send_frame(1, 0);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_ce0", ce0, 0); chk("wrst_wre1", wre1, 0);
    chk("wrst_start", fft_start, 0); chk("wrst_clear", fft_clear, 0);
    chk("wrst_done", frame_done, 0); chk("wrst_busy", busy, 0);
    chk("wrst_ad0", ad0, 0); chk("wrst_ad1", ad1, 0);
    chk("wrst_din0", din0, 0); chk("wrst_din1", din1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("wrst_ready", s_ready, 1);
    @(posedge clk); #1;
    arm_id++;
    send(32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    chk("wrst_restart_bank", first_bank, 0);
    chk("wrst_restart_ad", 32'(first_ad), 0);
    chk("wrst_restart_din", first_din, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
